// File: rtl/ram32x3_pkg.sv
// Shared constants and state/selector types for the 32x3 RAM controller.
package ram32x3_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 3;

  typedef enum logic {CLEAR, SERVE} ctrl_state_t;
  typedef enum logic {SEL_A, SEL_B} sel_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is requester A, bit 1 is requester B.
module rr_arb2
  import ram32x3_pkg::*;
(
  input  logic [1:0] req,
  input  sel_t       last,
  output logic [1:0] gnt
);

  // On a tie, the requester that did not win last time takes the grant.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == SEL_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram32x3_ctrl.sv
// Controller in front of a 32x3 single-port RAM: clear sweep after reset or
// on request, round-robin sharing between two requesters, registered read return.
module ram32x3_ctrl #(
  parameter int                        ADDR_W  = ram32x3_pkg::ADDR_W,
  parameter int                        DATA_W  = ram32x3_pkg::DATA_W,
  parameter logic [DATA_W-1:0]         CLR_VAL = '0
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              ClearReq,
  input  logic              ReqA,
  input  logic              WrA,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [DATA_W-1:0] DinA,
  output logic              GntA,
  output logic              RvalidA,
  output logic [DATA_W-1:0] DoutA,
  input  logic              ReqB,
  input  logic              WrB,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] DinB,
  output logic              GntB,
  output logic              RvalidB,
  output logic [DATA_W-1:0] DoutB,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataIn,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemDataOut,
  output logic              Busy
);

  import ram32x3_pkg::*;

  ctrl_state_t       state;
  logic [ADDR_W-1:0] clr_addr;
  sel_t              last_gnt;
  logic              serve_en;
  logic [1:0]        arb_req;
  logic [1:0]        gnt;

  // A clear request in SERVE suppresses all grants for that cycle.
  assign serve_en = (state == SERVE) && !ClearReq;
  assign arb_req  = serve_en ? {ReqB, ReqA} : 2'b00;

  rr_arb2 u_arb (
    .req  (arb_req),
    .last (last_gnt),
    .gnt  (gnt)
  );

  assign GntA = gnt[0];
  assign GntB = gnt[1];
  assign Busy = (state == CLEAR);

  always_comb begin
    MemAddress = '0;
    MemDataIn  = '0;
    MemWrite   = 1'b0;
    if (state == CLEAR) begin
      MemAddress = clr_addr;
      MemDataIn  = CLR_VAL;
      MemWrite   = 1'b1;
    end else if (gnt[0]) begin
      MemAddress = AddrA;
      MemDataIn  = DinA;
      MemWrite   = WrA;
    end else if (gnt[1]) begin
      MemAddress = AddrB;
      MemDataIn  = DinB;
      MemWrite   = WrB;
    end
  end

  // Sweep sequencing, grant history and read-return capture.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      last_gnt <= SEL_B;
      RvalidA  <= 1'b0;
      RvalidB  <= 1'b0;
      DoutA    <= '0;
      DoutB    <= '0;
    end else begin
      RvalidA <= 1'b0;
      RvalidB <= 1'b0;
      case (state)
        CLEAR: begin
          if (&clr_addr) begin
            state    <= SERVE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        SERVE: begin
          if (ClearReq) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end else if (gnt[0]) begin
            last_gnt <= SEL_A;
            if (!WrA) begin
              DoutA   <= MemDataOut;
              RvalidA <= 1'b1;
            end
          end else if (gnt[1]) begin
            last_gnt <= SEL_B;
            if (!WrB) begin
              DoutB   <= MemDataOut;
              RvalidB <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ram32x3_ctrl.sv
// Directed bench for ram32x3_ctrl with the 32x3 RAM modelled behind it.
module tb_ram32x3_ctrl;

  logic       CLK = 1'b0;
  logic       Reset_n;
  logic       ClearReq;
  logic       ReqA, WrA, ReqB, WrB;
  logic [4:0] AddrA, AddrB;
  logic [2:0] DinA, DinB;
  logic       GntA, GntB, RvalidA, RvalidB, MemWrite, Busy;
  logic [2:0] DoutA, DoutB, MemDataIn, MemDataOut;
  logic [4:0] MemAddress;
  logic [2:0] ram [32];

  int checks = 0;
  int passes = 0;

  always #5 CLK = ~CLK;

  ram32x3_ctrl dut (
    .CLK(CLK), .Reset_n(Reset_n), .ClearReq(ClearReq),
    .ReqA(ReqA), .WrA(WrA), .AddrA(AddrA), .DinA(DinA),
    .GntA(GntA), .RvalidA(RvalidA), .DoutA(DoutA),
    .ReqB(ReqB), .WrB(WrB), .AddrB(AddrB), .DinB(DinB),
    .GntB(GntB), .RvalidB(RvalidB), .DoutB(DoutB),
    .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemWrite(MemWrite),
    .MemDataOut(MemDataOut), .Busy(Busy)
  );

  // 32x3 RAM: synchronous write, combinational read.
  always @(posedge CLK) if (MemWrite) ram[MemAddress] <= MemDataIn;
  assign MemDataOut = ram[MemAddress];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic ra, input logic wa, input logic [4:0] aa,
                               input logic [2:0] da, input logic rb, input logic wb,
                               input logic [4:0] ab, input logic [2:0] db);
    ReqA = ra; WrA = wa; AddrA = aa; DinA = da;
    ReqB = rb; WrB = wb; AddrB = ab; DinB = db;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic sweepCheck(input string tag);
    for (int i = 0; i < 32; i++) begin
      settle();
      checkOutput({tag, "_busy"}, {7'd0, Busy}, 8'd1);
      checkOutput({tag, "_we"}, {7'd0, MemWrite}, 8'd1);
      checkOutput({tag, "_addr"}, {3'd0, MemAddress}, 8'(i));
      checkOutput({tag, "_gnta"}, {7'd0, GntA}, 8'd0);
      tick();
    end
    checkOutput({tag, "_done"}, {7'd0, Busy}, 8'd0);
  endtask

  task automatic readAllA(input string tag);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 5'(i), 3'd0, 1'b0, 1'b0, 5'd0, 3'd0);
      settle();
      checkOutput({tag, "_gnt"}, {7'd0, GntA}, 8'd1);
      tick();
      checkOutput({tag, "_rv"}, {7'd0, RvalidA}, 8'd1);
      checkOutput({tag, "_dout"}, {5'd0, DoutA}, 8'd0);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 3'd0);
    tick();
    checkOutput({tag, "_rv_end"}, {7'd0, RvalidA}, 8'd0);
  endtask

  initial begin
    Reset_n  = 1'b0;
    ClearReq = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 3'd0);
    tick();
    tick();
    checkOutput("rst_busy", {7'd0, Busy}, 8'd1);
    checkOutput("rst_rva", {7'd0, RvalidA}, 8'd0);
    checkOutput("rst_douta", {5'd0, DoutA}, 8'd0);
    checkOutput("rst_doutb", {5'd0, DoutB}, 8'd0);
    checkOutput("rst_addr", {3'd0, MemAddress}, 8'd0);

    Reset_n = 1'b1;
    sweepCheck("sweep0");
    readAllA("read0");

    // A writes 5 at 7, then B reads it back.
    applyStimulus(1'b1, 1'b1, 5'd7, 3'b101, 1'b0, 1'b0, 5'd0, 3'd0);
    settle();
    checkOutput("wr_gnta", {7'd0, GntA}, 8'd1);
    checkOutput("wr_we", {7'd0, MemWrite}, 8'd1);
    checkOutput("wr_addr", {3'd0, MemAddress}, 8'd7);
    checkOutput("wr_din", {5'd0, MemDataIn}, 8'd5);
    tick();
    checkOutput("wr_norv", {7'd0, RvalidA}, 8'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 5'd7, 3'd0);
    settle();
    checkOutput("rdb_gntb", {7'd0, GntB}, 8'd1);
    checkOutput("rdb_we", {7'd0, MemWrite}, 8'd0);
    tick();
    checkOutput("rdb_rv", {7'd0, RvalidB}, 8'd1);
    checkOutput("rdb_dout", {5'd0, DoutB}, 8'd5);

    // Both requesting every cycle: A, B, A, B ...
    applyStimulus(1'b1, 1'b0, 5'd7, 3'd0, 1'b1, 1'b0, 5'd7, 3'd0);
    for (int k = 0; k < 6; k++) begin
      settle();
      checkOutput("rr_gnta", {7'd0, GntA}, 8'(k % 2 == 0));
      checkOutput("rr_gntb", {7'd0, GntB}, 8'(k % 2 == 1));
      tick();
      checkOutput("rr_rva", {7'd0, RvalidA}, 8'(k % 2 == 0));
      checkOutput("rr_rvb", {7'd0, RvalidB}, 8'(k % 2 == 1));
    end
    checkOutput("rr_douta", {5'd0, DoutA}, 8'd5);

    // Clear request beats a pending A read.
    applyStimulus(1'b1, 1'b0, 5'd7, 3'd0, 1'b0, 1'b0, 5'd0, 3'd0);
    ClearReq = 1'b1;
    settle();
    checkOutput("clr_nognt", {7'd0, GntA}, 8'd0);
    checkOutput("clr_nowe", {7'd0, MemWrite}, 8'd0);
    tick();
    ClearReq = 1'b0;
    sweepCheck("sweep1");
    settle();
    checkOutput("clr_gnta", {7'd0, GntA}, 8'd1);
    tick();
    checkOutput("clr_rva", {7'd0, RvalidA}, 8'd1);
    checkOutput("clr_douta", {5'd0, DoutA}, 8'd0);
    readAllA("read1");

    // Reset in the middle of a sweep, with DoutB still holding 5.
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checkOutput("mid_addr15", {3'd0, MemAddress}, 8'd15);
    checkOutput("mid_doutb", {5'd0, DoutB}, 8'd5);
    Reset_n = 1'b0;
    settle();
    checkOutput("mid_rst_addr", {3'd0, MemAddress}, 8'd0);
    checkOutput("mid_rst_doutb", {5'd0, DoutB}, 8'd0);
    checkOutput("mid_rst_busy", {7'd0, Busy}, 8'd1);
    tick();
    Reset_n = 1'b1;
    sweepCheck("sweep2");

    // Seed distinct values at 31 and 0, then B reads them back-to-back.
    applyStimulus(1'b1, 1'b1, 5'd31, 3'd3, 1'b0, 1'b0, 5'd0, 3'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd0, 3'd6, 1'b0, 1'b0, 5'd0, 3'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 5'd31, 3'd0);
    settle();
    checkOutput("b2b_gnt0", {7'd0, GntB}, 8'd1);
    tick();
    checkOutput("b2b_rv0", {7'd0, RvalidB}, 8'd1);
    checkOutput("b2b_dout0", {5'd0, DoutB}, 8'd3);
    AddrB = 5'd0;
    settle();
    checkOutput("b2b_gnt1", {7'd0, GntB}, 8'd1);
    tick();
    checkOutput("b2b_rv1", {7'd0, RvalidB}, 8'd1);
    checkOutput("b2b_dout1", {5'd0, DoutB}, 8'd6);
    ReqB = 1'b0;
    tick();
    checkOutput("b2b_rv_end", {7'd0, RvalidB}, 8'd0);
    checkOutput("b2b_hold", {5'd0, DoutB}, 8'd6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
